// File: rtl/mips_core_pkg.sv
// Shared core types: branch outcome, 2-bit direction counter and its saturating update.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

package mips_core_pkg;
  localparam int ADDR_W         = `ADDR_WIDTH;
  localparam int BTB_INDEX_BITS = 6;

  typedef enum logic {NOT_TAKEN = 1'b0, TAKEN = 1'b1} BranchOutcome;

  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } CtrState;

  function automatic CtrState next_ctr(input CtrState c, input BranchOutcome o);
    CtrState n;
    n = c;
    if (o == TAKEN) begin
      if (c != STRONG_T) n = CtrState'(c + 2'b01);
    end else begin
      if (c != STRONG_NT) n = CtrState'(c - 2'b01);
    end
    return n;
  endfunction
endpackage

// File: rtl/mips_core_ifc.sv
// Fetch PC, prediction and branch resolution bundles exchanged between fetch and decode.
interface pc_ifc;
  import mips_core_pkg::*;
  logic [ADDR_W-1:0] pc;
  modport in  (input  pc);
  modport out (output pc);
endinterface

interface branch_prediction_ifc;
  import mips_core_pkg::*;
  logic              is_branch;
  logic [ADDR_W-1:0] target;
  BranchOutcome      prediction;
  modport in  (input  is_branch, target, prediction);
  modport out (output is_branch, target, prediction);
endinterface

interface branch_resolution_ifc;
  import mips_core_pkg::*;
  logic              is_branch;
  logic [ADDR_W-1:0] target;
  BranchOutcome      prediction;
  BranchOutcome      outcome;
  modport in  (input  is_branch, target, prediction, outcome);
  modport out (output is_branch, target, prediction, outcome);
endinterface

// File: rtl/btb_entry_array.sv
// Direct-mapped BTB storage: lookup and training read ports, one write port, bulk invalidate.
module btb_entry_array
  import mips_core_pkg::*;
#(
  parameter int INDEX_BITS = BTB_INDEX_BITS,
  parameter int TAG_BITS   = ADDR_W - BTB_INDEX_BITS - 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [INDEX_BITS-1:0] lk_idx,
  output logic                  lk_valid,
  output logic [TAG_BITS-1:0]   lk_tag,
  output logic [ADDR_W-1:0]     lk_target,
  output CtrState               lk_ctr,
  input  logic [INDEX_BITS-1:0] tr_idx,
  output logic                  tr_valid,
  output logic [TAG_BITS-1:0]   tr_tag,
  output CtrState               tr_ctr,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_idx,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  logic [ADDR_W-1:0]     wr_target,
  input  CtrState               wr_ctr,
  input  logic                  clear
);
  localparam int ENTRIES = 1 << INDEX_BITS;

  logic [ENTRIES-1:0] valid_q, valid_d;
  CtrState            ctr_q    [ENTRIES];
  CtrState            ctr_d    [ENTRIES];
  logic [TAG_BITS-1:0] tag_q   [ENTRIES];
  logic [TAG_BITS-1:0] tag_d   [ENTRIES];
  logic [ADDR_W-1:0]  target_q [ENTRIES];
  logic [ADDR_W-1:0]  target_d [ENTRIES];

  assign lk_valid  = valid_q[lk_idx];
  assign lk_tag    = tag_q[lk_idx];
  assign lk_target = target_q[lk_idx];
  assign lk_ctr    = ctr_q[lk_idx];
  assign tr_valid  = valid_q[tr_idx];
  assign tr_tag    = tag_q[tr_idx];
  assign tr_ctr    = ctr_q[tr_idx];

  // Clear only drops valid bits; counters and payload survive for the next allocation.
  always_comb begin
    valid_d  = valid_q;
    ctr_d    = ctr_q;
    tag_d    = tag_q;
    target_d = target_q;
    if (clear) begin
      valid_d = '0;
    end else if (wr_en) begin
      valid_d[wr_idx]  = 1'b1;
      ctr_d[wr_idx]    = wr_ctr;
      tag_d[wr_idx]    = wr_tag;
      target_d[wr_idx] = wr_target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= WEAK_NT;
    end else begin
      valid_q <= valid_d;
      ctr_q   <= ctr_d;
    end
  end

  always_ff @(posedge clk) begin
    tag_q    <= tag_d;
    target_q <= target_d;
  end
endmodule

// File: rtl/branch_predictor.sv
// Fetch-side BTB predictor: zero-latency lookup, per-cycle training from decode, branch stats.
module branch_predictor
  import mips_core_pkg::*;
#(
  parameter int INDEX_BITS = BTB_INDEX_BITS,
  parameter int TAG_BITS   = ADDR_W - INDEX_BITS - 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  pc_ifc.in                        i_pc,
  branch_prediction_ifc.out        o_prediction,
  branch_resolution_ifc.in         i_resolution,
  input  logic [ADDR_W-1:0]        i_resolve_pc,
  input  logic                     i_update_en,
  input  logic                     i_clear,
  output logic [31:0]              o_branch_count,
  output logic [31:0]              o_mispredict_count
);
  logic [INDEX_BITS-1:0] lk_idx, tr_idx;
  logic [TAG_BITS-1:0]   lk_tag, tr_tag, lk_tag_rd, tr_tag_rd;
  logic                  lk_valid, tr_valid, lk_hit, tr_hit, upd;
  logic [ADDR_W-1:0]     lk_target;
  CtrState               lk_ctr, tr_ctr, wr_ctr;
  logic [31:0]           branch_count_q, branch_count_d;
  logic [31:0]           mispredict_count_q, mispredict_count_d;
  logic                  unused_pc_bits;

  assign lk_idx = i_pc.pc[INDEX_BITS+1:2];
  assign lk_tag = i_pc.pc[ADDR_W-1:INDEX_BITS+2];
  assign tr_idx = i_resolve_pc[INDEX_BITS+1:2];
  assign tr_tag = i_resolve_pc[ADDR_W-1:INDEX_BITS+2];
  assign unused_pc_bits = ^{i_pc.pc[1:0], i_resolve_pc[1:0]};

  btb_entry_array #(.INDEX_BITS(INDEX_BITS), .TAG_BITS(TAG_BITS)) u_array (
    .clk       (clk),
    .rst_n     (rst_n),
    .lk_idx    (lk_idx),
    .lk_valid  (lk_valid),
    .lk_tag    (lk_tag_rd),
    .lk_target (lk_target),
    .lk_ctr    (lk_ctr),
    .tr_idx    (tr_idx),
    .tr_valid  (tr_valid),
    .tr_tag    (tr_tag_rd),
    .tr_ctr    (tr_ctr),
    .wr_en     (upd),
    .wr_idx    (tr_idx),
    .wr_tag    (tr_tag),
    .wr_target (i_resolution.target),
    .wr_ctr    (wr_ctr),
    .clear     (i_clear)
  );

  // No bypass: a same-cycle update to the looked-up index is seen on the next cycle.
  assign lk_hit = lk_valid && (lk_tag_rd == lk_tag);
  assign o_prediction.is_branch  = lk_hit;
  assign o_prediction.target     = lk_hit ? lk_target : '0;
  assign o_prediction.prediction = (lk_hit && lk_ctr[1]) ? TAKEN : NOT_TAKEN;

  assign upd    = i_update_en && i_resolution.is_branch && !i_clear;
  assign tr_hit = tr_valid && (tr_tag_rd == tr_tag);

  always_comb begin
    if (tr_hit) wr_ctr = next_ctr(tr_ctr, i_resolution.outcome);
    else        wr_ctr = (i_resolution.outcome == TAKEN) ? WEAK_T : WEAK_NT;
  end

  always_comb begin
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    if (upd) begin
      branch_count_d = branch_count_q + 32'd1;
      if (i_resolution.prediction != i_resolution.outcome)
        mispredict_count_d = mispredict_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign o_branch_count     = branch_count_q;
  assign o_mispredict_count = mispredict_count_q;
endmodule

// File: tb/tb_branch_predictor.sv
// Directed vector bench for branch_predictor: table of per-cycle lookups/updates plus corner sequences.
module tb_branch_predictor;
  import mips_core_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] resolve_pc;
  logic        update_en, clear;
  logic [31:0] branch_count, mispredict_count;

  pc_ifc                pc_if ();
  branch_prediction_ifc pred_if ();
  branch_resolution_ifc res_if ();

  branch_predictor dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .i_pc               (pc_if),
    .o_prediction       (pred_if),
    .i_resolution       (res_if),
    .i_resolve_pc       (resolve_pc),
    .i_update_en        (update_en),
    .i_clear            (clear),
    .o_branch_count     (branch_count),
    .o_mispredict_count (mispredict_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]  pc;
    logic         upd_en;
    logic         is_br;
    logic [31:0]  rpc;
    logic [31:0]  tgt;
    BranchOutcome pred;
    BranchOutcome outc;
    logic         exp_hit;
    logic [31:0]  exp_tgt;
    BranchOutcome exp_pred;
    logic [31:0]  exp_bcnt;
    logic [31:0]  exp_mcnt;
  } vec_t;

  localparam logic [31:0] PC_A = 32'h0040_0010;
  localparam logic [31:0] PC_B = 32'h0040_0110;
  localparam logic [31:0] PC_C = 32'h0040_0020;
  localparam logic [31:0] T_A  = 32'h0040_0100;
  localparam logic [31:0] T_B  = 32'h0040_0200;
  localparam logic [31:0] T_C  = 32'h0040_0300;
  localparam logic [31:0] T_C2 = 32'h0040_0400;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_lookup(input string name, input logic hit, input logic [31:0] tgt,
                            input BranchOutcome pr);
    chk({name, ".is_branch"},  {31'd0, pred_if.is_branch}, {31'd0, hit});
    chk({name, ".target"},     pred_if.target, tgt);
    chk({name, ".prediction"}, {31'd0, pred_if.prediction}, {31'd0, pr});
  endtask

  task automatic chk_counts(input string name, input logic [31:0] b, input logic [31:0] m);
    chk({name, ".branch_count"},     branch_count, b);
    chk({name, ".mispredict_count"}, mispredict_count, m);
  endtask

  task automatic drive_upd(input logic en, input logic br, input logic [31:0] rpc,
                           input logic [31:0] tgt, input BranchOutcome pr, input BranchOutcome oc);
    update_en           = en;
    res_if.is_branch    = br;
    resolve_pc          = rpc;
    res_if.target       = tgt;
    res_if.prediction   = pr;
    res_if.outcome      = oc;
  endtask

  task automatic add(input logic [31:0] pc, input logic en, input logic br, input logic [31:0] rpc,
                     input logic [31:0] tgt, input BranchOutcome pr, input BranchOutcome oc,
                     input logic eh, input logic [31:0] et, input BranchOutcome ep,
                     input logic [31:0] eb, input logic [31:0] em);
    vec_t v;
    v.pc = pc; v.upd_en = en; v.is_br = br; v.rpc = rpc; v.tgt = tgt; v.pred = pr; v.outc = oc;
    v.exp_hit = eh; v.exp_tgt = et; v.exp_pred = ep; v.exp_bcnt = eb; v.exp_mcnt = em;
    vecs.push_back(v);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Each row: drive lookup PC + resolution, check pre-edge outputs, then clock the update.
    add(PC_A, 0, 0, 0,    0,    NOT_TAKEN, NOT_TAKEN, 0, 0,    NOT_TAKEN, 0,  0);
    add(PC_A, 1, 1, PC_A, T_A,  NOT_TAKEN, TAKEN,     0, 0,    NOT_TAKEN, 0,  0);
    add(PC_A, 1, 1, PC_A, T_A,  TAKEN,     TAKEN,     1, T_A,  TAKEN,     1,  1);
    add(PC_A, 1, 1, PC_A, T_A,  TAKEN,     TAKEN,     1, T_A,  TAKEN,     2,  1);
    add(PC_A, 1, 1, PC_A, T_A,  TAKEN,     TAKEN,     1, T_A,  TAKEN,     3,  1);
    add(PC_A, 1, 1, PC_A, T_A,  TAKEN,     NOT_TAKEN, 1, T_A,  TAKEN,     4,  1);
    add(PC_A, 1, 1, PC_A, T_A,  TAKEN,     NOT_TAKEN, 1, T_A,  TAKEN,     5,  2);
    add(PC_A, 1, 1, PC_A, T_A,  NOT_TAKEN, NOT_TAKEN, 1, T_A,  NOT_TAKEN, 6,  3);
    add(PC_A, 1, 1, PC_A, T_A,  NOT_TAKEN, NOT_TAKEN, 1, T_A,  NOT_TAKEN, 7,  3);
    add(PC_A, 1, 1, PC_A, T_A,  NOT_TAKEN, TAKEN,     1, T_A,  NOT_TAKEN, 8,  3);
    add(PC_A, 1, 1, PC_A, T_A,  NOT_TAKEN, TAKEN,     1, T_A,  NOT_TAKEN, 9,  4);
    add(PC_A, 1, 1, PC_B, T_B,  NOT_TAKEN, NOT_TAKEN, 1, T_A,  TAKEN,     10, 5);
    add(PC_A, 0, 0, 0,    0,    NOT_TAKEN, NOT_TAKEN, 0, 0,    NOT_TAKEN, 11, 5);
    add(PC_B, 0, 0, 0,    0,    NOT_TAKEN, NOT_TAKEN, 1, T_B,  NOT_TAKEN, 11, 5);
    add(PC_C, 1, 1, PC_C, T_C,  NOT_TAKEN, TAKEN,     0, 0,    NOT_TAKEN, 11, 5);
    add(PC_C, 0, 0, 0,    0,    NOT_TAKEN, NOT_TAKEN, 1, T_C,  TAKEN,     12, 6);
    add(PC_C, 1, 0, PC_C, T_B,  TAKEN,     NOT_TAKEN, 1, T_C,  TAKEN,     12, 6);
    add(PC_C, 0, 0, 0,    0,    NOT_TAKEN, NOT_TAKEN, 1, T_C,  TAKEN,     12, 6);
    add(PC_C, 1, 1, PC_C, T_C2, TAKEN,     TAKEN,     1, T_C,  TAKEN,     12, 6);
    add(PC_C, 0, 0, 0,    0,    NOT_TAKEN, NOT_TAKEN, 1, T_C2, TAKEN,     13, 6);

    rst_n = 1'b0;
    clear = 1'b0;
    pc_if.pc = PC_A;
    drive_upd(0, 0, 0, 0, NOT_TAKEN, NOT_TAKEN);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    next_cycle();

    chk_lookup("reset", 0, 0, NOT_TAKEN);
    chk_counts("reset", 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      pc_if.pc = vecs[i].pc;
      drive_upd(vecs[i].upd_en, vecs[i].is_br, vecs[i].rpc, vecs[i].tgt, vecs[i].pred, vecs[i].outc);
      #1;
      chk_lookup($sformatf("vec%0d", i), vecs[i].exp_hit, vecs[i].exp_tgt, vecs[i].exp_pred);
      chk_counts($sformatf("vec%0d", i), vecs[i].exp_bcnt, vecs[i].exp_mcnt);
      next_cycle();
    end
    drive_upd(0, 0, 0, 0, NOT_TAKEN, NOT_TAKEN);

    // Stalled decode: NOT_TAKEN resolutions held with update_en low must not train.
    pc_if.pc = PC_C;
    drive_upd(0, 1, PC_C, T_B, TAKEN, NOT_TAKEN);
    repeat (5) next_cycle();
    drive_upd(0, 0, 0, 0, NOT_TAKEN, NOT_TAKEN);
    #1;
    chk_lookup("stall", 1, T_C2, TAKEN);
    chk_counts("stall", 13, 6);

    // Clear wins over a same-cycle update, which is also not counted.
    clear = 1'b1;
    drive_upd(1, 1, PC_A, T_A, NOT_TAKEN, TAKEN);
    next_cycle();
    clear = 1'b0;
    drive_upd(0, 0, 0, 0, NOT_TAKEN, NOT_TAKEN);
    pc_if.pc = PC_C; #1; chk_lookup("clear_c", 0, 0, NOT_TAKEN);
    pc_if.pc = PC_B; #1; chk_lookup("clear_b", 0, 0, NOT_TAKEN);
    pc_if.pc = PC_A; #1; chk_lookup("clear_a", 0, 0, NOT_TAKEN);
    chk_counts("clear", 13, 6);

    // Retrain, then pull reset between edges and expect immediate miss/zero counts.
    next_cycle();
    pc_if.pc = PC_C;
    drive_upd(1, 1, PC_C, T_C, NOT_TAKEN, TAKEN);
    next_cycle();
    drive_upd(0, 0, 0, 0, NOT_TAKEN, NOT_TAKEN);
    #1;
    chk_lookup("retrain", 1, T_C, TAKEN);
    chk_counts("retrain", 14, 7);
    #1 rst_n = 1'b0;
    #1;
    chk_lookup("async_rst", 0, 0, NOT_TAKEN);
    chk_counts("async_rst", 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
    chk_lookup("post_rst", 0, 0, NOT_TAKEN);
    chk_counts("post_rst", 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
